// File: rtl/uart_pkg.sv
// Shared definitions for the UART host bus interface: register map, bit
// positions and the transmit handshake state encoding.
package uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_RX_FULL     = 1;
  localparam int unsigned ST_OVERRUN     = 2;
  localparam int unsigned ST_TX_HOLD     = 3;
  localparam int unsigned ST_TX_BUSY     = 4;

  localparam int unsigned CTRL_RX_IRQ_EN = 0;
  localparam int unsigned CTRL_TX_IRQ_EN = 1;
  localparam int unsigned CTRL_CLR_OVR   = 2;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous circular-buffer FIFO for received bytes; the head byte is
// presented combinationally so a pop can be read in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [PTR_W:0]    o_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  // A pop at full frees the slot the simultaneous push needs.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_bus_if.sv
// Register-mapped host interface between the UART engines and the CPU bus:
// RX edge capture into a FIFO, TX holding register with start/busy handshake.
module uart_bus_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic [1:0]        bus_addr,
  input  logic              bus_we,
  input  logic              bus_re,
  input  logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] bus_rdata,
  output logic              irq
);

  logic              r_rx_ready_q;
  logic [1:0]        r_ctrl;
  logic              r_overrun;
  logic [DATA_W-1:0] r_rdata;
  logic              r_irq;
  tx_state_t         r_state;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_nonempty;
  logic [PTR_W:0]    w_count;
  logic [DATA_W-1:0] w_head;
  logic              w_overflow;
  logic              w_rd_data;
  logic              w_wr_data;
  logic              w_wr_ctrl;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_rd_mux;

  assign w_push     = rx_ready & ~r_rx_ready_q;
  assign w_rd_data  = bus_re & (bus_addr == ADDR_DATA);
  assign w_wr_data  = bus_we & (bus_addr == ADDR_DATA);
  assign w_wr_ctrl  = bus_we & (bus_addr == ADDR_CTRL);
  assign w_pop      = w_rd_data & ~w_empty;
  assign w_nonempty = (w_count != '0);
  assign w_overflow = w_push & w_full & ~w_pop;

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .PTR_W  (PTR_W)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (rx_data),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_status                 = '0;
    w_status[ST_RX_NONEMPTY] = w_nonempty;
    w_status[ST_RX_FULL]     = w_full;
    w_status[ST_OVERRUN]     = r_overrun;
    w_status[ST_TX_HOLD]     = r_hold_full;
    w_status[ST_TX_BUSY]     = tx_busy;
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus_addr)
      ADDR_DATA:   w_rd_mux = w_empty ? '0 : w_head;
      ADDR_STATUS: w_rd_mux = w_status;
      ADDR_CTRL:   w_rd_mux[1:0] = r_ctrl;
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ready_q <= 1'b0;
      r_ctrl       <= '0;
      r_overrun    <= 1'b0;
      r_rdata      <= '0;
      r_irq        <= 1'b0;
    end else begin
      r_rx_ready_q <= rx_ready;
      if (w_wr_ctrl) r_ctrl <= bus_wdata[1:0];
      // Overflow takes priority over a clear in the same cycle.
      if (w_overflow)
        r_overrun <= 1'b1;
      else if (w_wr_ctrl && bus_wdata[CTRL_CLR_OVR])
        r_overrun <= 1'b0;
      if (bus_re) r_rdata <= w_rd_mux;
      r_irq <= (r_ctrl[CTRL_RX_IRQ_EN] & w_nonempty) |
               (r_ctrl[CTRL_TX_IRQ_EN] & ~r_hold_full);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= TX_IDLE;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      case (r_state)
        TX_IDLE: if (r_hold_full && !tx_busy) begin
          r_tx_data  <= r_hold;
          r_tx_start <= 1'b1;
          r_state    <= TX_REQ;
        end
        // Freeing the holding register on acceptance lets the CPU queue the next byte.
        TX_REQ: if (tx_busy) begin
          r_tx_start  <= 1'b0;
          r_hold_full <= 1'b0;
          r_state     <= TX_WAIT;
        end
        TX_WAIT: if (!tx_busy) r_state <= TX_IDLE;
        default: r_state <= TX_IDLE;
      endcase
      if (w_wr_data && !r_hold_full) begin
        r_hold      <= bus_wdata;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign tx_start  = r_tx_start;
  assign tx_data   = r_tx_data;
  assign bus_rdata = r_rdata;
  assign irq       = r_irq;

endmodule

// File: tb/tb_uart_bus_if.sv
// Directed bench for uart_bus_if: a one-cycle-per-row vector table for the
// RX/register paths, plus hand sequences for FIFO full, TX handshake and irq.
module tb_uart_bus_if;

  localparam logic [1:0] A_D = 2'd0;
  localparam logic [1:0] A_S = 2'd1;
  localparam logic [1:0] A_C = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [1:0] bus_addr = '0;
  logic       bus_we = 1'b0;
  logic       bus_re = 1'b0;
  logic [7:0] bus_wdata = '0;
  logic [7:0] bus_rdata;
  logic       irq;

  int n_run  = 0;
  int n_fail = 0;

  uart_bus_if #(.DATA_W(8), .FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rr;
    logic [7:0] rd;
    logic       we;
    logic       re;
    logic [1:0] a;
    logic [7:0] wd;
    logic       cr;
    logic [7:0] er;
    logic       ci;
    logic       ei;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rr, logic [7:0] rd, logic we, logic re,
                              logic [1:0] a, logic [7:0] wd, logic cr,
                              logic [7:0] er, logic ci, logic ei, string nm);
    vec_t v;
    v.rr = rr; v.rd = rd; v.we = we; v.re = re; v.a = a; v.wd = wd;
    v.cr = cr; v.er = er; v.ci = ci; v.ei = ei; v.nm = nm;
    return v;
  endfunction

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at a negedge, return at the next negedge.
  task automatic step(input logic rr, input logic [7:0] rd, input logic we,
                      input logic re, input logic [1:0] a, input logic [7:0] wd);
    rx_ready = rr; rx_data = rd; bus_we = we; bus_re = re;
    bus_addr = a; bus_wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    step(rx_ready, rx_data, 1'b0, 1'b0, A_D, 8'h00);
  endtask

  task automatic rd(input logic [1:0] a);
    step(rx_ready, rx_data, 1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    step(rx_ready, rx_data, 1'b1, 1'b0, a, d);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, A_D, 8'h00);
    step(1'b0, d, 1'b0, 1'b0, A_D, 8'h00);
  endtask

  initial begin
    // Reset, status and basic RX, overflow, overrun clear, CTRL read-before-write.
    tbl.push_back(mk(0, 8'h00, 0, 1, A_S, 8'h00, 1, 8'h00, 1, 0, "reset_status"));
    tbl.push_back(mk(1, 8'h41, 0, 0, A_D, 8'h00, 0, 8'h00, 0, 0, "push41"));
    tbl.push_back(mk(0, 8'h41, 0, 0, A_D, 8'h00, 0, 8'h00, 0, 0, "rel41"));
    tbl.push_back(mk(1, 8'h42, 0, 0, A_D, 8'h00, 0, 8'h00, 0, 0, "push42"));
    tbl.push_back(mk(0, 8'h42, 0, 1, A_S, 8'h00, 1, 8'h01, 1, 0, "status_two"));
    tbl.push_back(mk(0, 8'h42, 0, 1, A_D, 8'h00, 1, 8'h41, 0, 0, "read41"));
    tbl.push_back(mk(0, 8'h42, 0, 0, A_D, 8'h00, 1, 8'h41, 0, 0, "rdata_hold"));
    tbl.push_back(mk(0, 8'h42, 0, 1, A_D, 8'h00, 1, 8'h42, 0, 0, "read42"));
    tbl.push_back(mk(0, 8'h42, 0, 1, A_D, 8'h00, 1, 8'h00, 0, 0, "read_empty"));
    tbl.push_back(mk(0, 8'h42, 0, 1, A_S, 8'h00, 1, 8'h00, 0, 0, "status_empty"));
    for (int unsigned k = 0; k < 5; k++) begin
      tbl.push_back(mk(1, 8'h10 + 8'(k), 0, 0, A_D, 8'h00, 0, 8'h00, 0, 0, "push1x"));
      tbl.push_back(mk(0, 8'h10 + 8'(k), 0, 0, A_D, 8'h00, 0, 8'h00, 0, 0, "rel1x"));
    end
    tbl.push_back(mk(0, 8'h14, 0, 1, A_S, 8'h00, 1, 8'h07, 0, 0, "status_ovr"));
    for (int unsigned k = 0; k < 4; k++)
      tbl.push_back(mk(0, 8'h14, 0, 1, A_D, 8'h00, 1, 8'h10 + 8'(k), 0, 0, "read1x"));
    tbl.push_back(mk(0, 8'h14, 0, 1, A_S, 8'h00, 1, 8'h04, 0, 0, "ovr_sticky"));
    tbl.push_back(mk(0, 8'h14, 1, 0, A_C, 8'h04, 0, 8'h00, 0, 0, "clr_ovr"));
    tbl.push_back(mk(0, 8'h14, 0, 1, A_S, 8'h00, 1, 8'h00, 0, 0, "status_clr"));
    tbl.push_back(mk(0, 8'h14, 0, 1, A_C, 8'h00, 1, 8'h00, 0, 0, "ctrl_bit2_nostore"));
    tbl.push_back(mk(0, 8'h14, 0, 1, 2'd3, 8'h00, 1, 8'h00, 0, 0, "addr3_read"));
    tbl.push_back(mk(0, 8'h14, 1, 1, A_C, 8'h03, 1, 8'h00, 0, 0, "we_re_prewrite"));
    tbl.push_back(mk(0, 8'h14, 0, 1, A_C, 8'h00, 1, 8'h03, 1, 1, "ctrl_read"));
    tbl.push_back(mk(0, 8'h14, 1, 0, A_C, 8'h00, 0, 8'h00, 0, 0, "ctrl_zero"));
    tbl.push_back(mk(0, 8'h14, 0, 0, A_D, 8'h00, 0, 8'h00, 1, 0, "irq_off"));

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check1("reset_tx_start", tx_start, 1'b0);
    check8("reset_tx_data", tx_data, 8'h00);
    check1("reset_irq", irq, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rr, tbl[i].rd, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].wd);
      if (tbl[i].cr) check8({tbl[i].nm, "_rdata"}, bus_rdata, tbl[i].er);
      if (tbl[i].ci) check1({tbl[i].nm, "_irq"}, irq, tbl[i].ei);
    end

    // Push and pop together at full: no overrun, new byte becomes the tail.
    for (int unsigned k = 0; k < 4; k++) push(8'h20 + 8'(k));
    step(1'b1, 8'h24, 1'b0, 1'b1, A_D, 8'h00);
    check8("full_pushpop_read", bus_rdata, 8'h20);
    step(1'b0, 8'h24, 1'b0, 1'b1, A_S, 8'h00);
    check8("full_pushpop_status", bus_rdata, 8'h03);
    for (int unsigned k = 0; k < 4; k++) begin
      rd(A_D);
      check8("full_drain", bus_rdata, 8'h21 + 8'(k));
    end
    rd(A_S);
    check8("drained_status", bus_rdata, 8'h00);
    // Push and pop together at empty: only the push happens.
    step(1'b1, 8'h30, 1'b0, 1'b1, A_D, 8'h00);
    check8("empty_pushpop_read", bus_rdata, 8'h00);
    step(1'b0, 8'h30, 1'b0, 1'b1, A_S, 8'h00);
    check8("empty_pushpop_status", bus_rdata, 8'h01);
    rd(A_D);
    check8("empty_pushpop_byte", bus_rdata, 8'h30);

    // TX handshake.
    wr(A_D, 8'h55);
    check1("tx_load_nostart", tx_start, 1'b0);
    idle();
    check1("tx_start_up", tx_start, 1'b1);
    check8("tx_data_55", tx_data, 8'h55);
    idle();
    rd(A_S);
    check1("tx_start_held", tx_start, 1'b1);
    check8("tx_data_held", tx_data, 8'h55);
    check8("status_hold", bus_rdata, 8'h08);
    tx_busy = 1'b1;
    idle();
    check1("tx_start_drop", tx_start, 1'b0);
    rd(A_S);
    check8("status_busy", bus_rdata, 8'h10);
    wr(A_D, 8'hAA);
    rd(A_S);
    check8("status_busy_hold", bus_rdata, 8'h18);
    repeat (3) idle();
    check1("tx_wait_busy", tx_start, 1'b0);
    tx_busy = 1'b0;
    idle();
    check1("tx_wait_exit", tx_start, 1'b0);
    idle();
    check1("tx_restart", tx_start, 1'b1);
    check8("tx_data_aa", tx_data, 8'hAA);
    tx_busy = 1'b1;
    idle();
    check1("tx_restart_drop", tx_start, 1'b0);
    tx_busy = 1'b0;
    idle();
    idle();
    rd(A_S);
    check8("tx_done_status", bus_rdata, 8'h00);

    // Interrupts.
    wr(A_C, 8'h01);
    idle();
    check1("irq_rx_empty", irq, 1'b0);
    step(1'b1, 8'h61, 1'b0, 1'b0, A_D, 8'h00);
    check1("irq_rx_lag", irq, 1'b0);
    step(1'b0, 8'h61, 1'b0, 1'b0, A_D, 8'h00);
    check1("irq_rx_set", irq, 1'b1);
    rd(A_D);
    check8("irq_rx_read", bus_rdata, 8'h61);
    check1("irq_rx_still", irq, 1'b1);
    idle();
    check1("irq_rx_clear", irq, 1'b0);
    wr(A_C, 8'h02);
    idle();
    check1("irq_tx_empty", irq, 1'b1);

    // Reset in the middle of a transmit request.
    wr(A_D, 8'h77);
    idle();
    check1("pre_reset_start", tx_start, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("midreset_start", tx_start, 1'b0);
    check8("midreset_data", tx_data, 8'h00);
    check8("midreset_rdata", bus_rdata, 8'h00);
    check1("midreset_irq", irq, 1'b0);
    rd(A_S);
    check8("midreset_status", bus_rdata, 8'h00);
    idle();
    check1("midreset_no_restart", tx_start, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
